// File: rtl/if_fetch_unit.sv
// if_fetch_unit
//   Instruction-fetch stage feeding the IF/ID register. Owns the program
//   counter, issues one word read at a time to instruction memory and keeps
//   returned words in a 2-entry queue. It applies taken-branch redirects
//   from EX: the queue is flushed, and any in-flight response is discarded.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   stall             ID stall; head entry is held while 1
//   nPC_sel           taken branch this cycle (overrides everything)
//   imm16, br_pc4     branch word offset and PC+4 of the branch
//   imem_req/adr      read request and word address to instruction memory
//   imem_rvalid/rdata read response from instruction memory
//   inst, inst_pc4    head instruction and its PC+4
//   inst_valid        head entry present
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        nPC_sel,
  input  logic [15:0] imm16,
  input  logic [31:0] br_pc4,
  output logic        imem_req,
  output logic [31:0] imem_adr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst,
  output logic [31:0] inst_pc4,
  output logic        inst_valid
);

  // IDLE: nothing outstanding; WAIT: response will be kept;
  // KILL: response will be discarded (a redirect overtook it).
  typedef enum logic [1:0] {IDLE, WAIT, KILL} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic [1:0]  count_q, count_d;
  logic        wr_ptr_q, rd_ptr_q;
  logic [31:0] fifo_inst_q [2];
  logic [31:0] fifo_pc4_q  [2];
  logic [31:0] last_inst_q, last_pc4_q;

  logic        push, pop, issue;
  logic [1:0]  count_after;
  logic [31:0] br_target;

  assign br_target = br_pc4 + {{14{imm16[15]}}, imm16, 2'b00};

  assign pop  = (count_q != 2'd0) && !stall && !nPC_sel;
  assign push = (state_q == WAIT) && imem_rvalid && !nPC_sel;
  assign count_after = count_q + {1'b0, push} - {1'b0, pop};

  always_comb begin
    issue    = 1'b0;
    state_d  = state_q;
    pc_d     = pc_q;
    req_pc_d = req_pc_q;
    count_d  = count_after;
    if (nPC_sel) begin
      pc_d    = br_target;
      count_d = 2'd0;
      case (state_q)
        WAIT, KILL: state_d = imem_rvalid ? IDLE : KILL;
        default:    state_d = IDLE;
      endcase
    end else begin
      case (state_q)
        IDLE: if (count_q < 2'd2) issue = 1'b1;
        WAIT: begin
          // Back-to-back issue only when the slot freed by this response
          // still leaves room; otherwise go idle until the queue drains.
          if (imem_rvalid) begin
            if (count_after < 2'd2) issue = 1'b1;
            else                    state_d = IDLE;
          end
        end
        KILL: if (imem_rvalid) state_d = IDLE;
        default: state_d = IDLE;
      endcase
      if (issue) begin
        pc_d     = pc_q + 32'd4;
        req_pc_d = pc_q;
        state_d  = WAIT;
      end
    end
  end

  // Reset gates the request combinationally so memory sees nothing while
  // rst_n is low, even though the idle/empty state would otherwise issue.
  assign imem_req = issue & rst_n;
  assign imem_adr = pc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC;
      req_pc_q    <= RESET_PC;
      count_q     <= 2'd0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      last_inst_q <= 32'd0;
      last_pc4_q  <= 32'd0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
      count_q  <= count_d;
      if (nPC_sel) begin
        wr_ptr_q <= 1'b0;
        rd_ptr_q <= 1'b0;
      end else begin
        if (push) wr_ptr_q <= ~wr_ptr_q;
        if (pop) begin
          rd_ptr_q    <= ~rd_ptr_q;
          // Remember the consumed entry so outputs hold it once empty.
          last_inst_q <= fifo_inst_q[rd_ptr_q];
          last_pc4_q  <= fifo_pc4_q[rd_ptr_q];
        end
      end
    end
  end

  // Queue storage carries data only; validity is tracked by count_q.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_inst_q[wr_ptr_q] <= imem_rdata;
      fifo_pc4_q[wr_ptr_q]  <= req_pc_q + 32'd4;
    end
  end

  assign inst_valid = (count_q != 2'd0);
  assign inst       = inst_valid ? fifo_inst_q[rd_ptr_q] : last_inst_q;
  assign inst_pc4   = inst_valid ? fifo_pc4_q[rd_ptr_q]  : last_pc4_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
module tb_if_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        nPC_sel;
  logic [15:0] imm16;
  logic [31:0] br_pc4;
  logic        imem_req;
  logic [31:0] imem_adr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] inst;
  logic [31:0] inst_pc4;
  logic        inst_valid;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc4;
  } exp_t;
  exp_t exp_q[$];

  if_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall       (stall),
    .nPC_sel     (nPC_sel),
    .imm16       (imm16),
    .br_pc4      (br_pc4),
    .imem_req    (imem_req),
    .imem_adr    (imem_adr),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .inst        (inst),
    .inst_pc4    (inst_pc4),
    .inst_valid  (inst_valid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Instruction memory: returns the requested address as data, lat cycles
  // after the request cycle.
  int          lat = 1;
  logic        pend;
  int          rem;
  logic [31:0] padr;
  initial begin
    imem_rvalid = 1'b0;
    imem_rdata  = 32'd0;
    pend = 1'b0;
    rem  = 0;
    padr = 32'd0;
    forever begin
      @(negedge clk);
      if (imem_req) begin
        pend = 1'b1;
        rem  = lat;
        padr = imem_adr;
      end
      @(posedge clk);
      #1;
      imem_rvalid = 1'b0;
      if (pend) begin
        rem = rem - 1;
        if (rem == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata  = padr;
          pend = 1'b0;
        end
      end
    end
  end

  task automatic push_exp(input logic [31:0] a);
    exp_t e;
    e.inst = a;
    e.pc4  = a + 32'd4;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Monitor: every consumed head entry is matched against the scoreboard.
  always @(negedge clk) begin
    if (rst_n && inst_valid && !stall && !nPC_sel) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got inst %h pc4 %h, expected nothing", inst, inst_pc4);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (inst !== e.inst || inst_pc4 !== e.pc4) begin
          errors++;
          $display("FAIL sb_pop: got inst %h pc4 %h, expected inst %h pc4 %h",
                   inst, inst_pc4, e.inst, e.pc4);
        end
      end
    end
  end

  initial begin
    logic [31:0] a_list [15];
    logic [31:0] b_list [7];
    a_list = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h14, 32'h18, 32'h1C,
               32'h38, 32'h3C, 32'h40, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0, 32'h4};
    b_list = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h140, 32'h200, 32'h204};

    rst_n   = 1'b0;
    stall   = 1'b0;
    nPC_sel = 1'b0;
    imm16   = 16'h0;
    br_pc4  = 32'h0;
    foreach (a_list[i]) push_exp(a_list[i]);

    #2;
    chk("rst_req",   {31'd0, imem_req},   32'd0);
    chk("rst_valid", {31'd0, inst_valid}, 32'd0);
    chk("rst_inst",  inst,     32'd0);
    chk("rst_pc4",   inst_pc4, 32'd0);

    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int c = 0; c < 61; c++) begin
      case (c)
        4:  stall = 1'b1;
        9:  stall = 1'b0;
        16: begin nPC_sel = 1'b1; br_pc4 = 32'h40;  imm16 = 16'hFFFE; end
        17: nPC_sel = 1'b0;
        22: begin nPC_sel = 1'b1; br_pc4 = 32'h10;  imm16 = 16'hFFFA; end
        23: nPC_sel = 1'b0;
        29: begin
          #1 rst_n = 1'b0;
          #1;
          chk("mrst_req",   {31'd0, imem_req},   32'd0);
          chk("mrst_valid", {31'd0, inst_valid}, 32'd0);
          chk("mrst_inst",  inst,     32'd0);
          chk("mrst_pc4",   inst_pc4, 32'd0);
          chk("phaseA_drained", exp_q.size(), 32'd0);
          foreach (b_list[i]) push_exp(b_list[i]);
          #1 rst_n = 1'b1;
        end
        31: lat = 3;
        39: begin nPC_sel = 1'b1; br_pc4 = 32'h100; imm16 = 16'h0010; end
        40: nPC_sel = 1'b0;
        47: begin nPC_sel = 1'b1; br_pc4 = 32'h200; imm16 = 16'h0000; end
        48: nPC_sel = 1'b0;
        56: stall = 1'b1;
        default: ;
      endcase

      @(negedge clk);
      case (c)
        0: begin
          chk("c0_req", {31'd0, imem_req}, 32'd1);
          chk("c0_adr", imem_adr, 32'h0);
          chk("c0_valid", {31'd0, inst_valid}, 32'd0);
        end
        1: begin
          chk("c1_req", {31'd0, imem_req}, 32'd1);
          chk("c1_adr", imem_adr, 32'h4);
          chk("c1_valid", {31'd0, inst_valid}, 32'd0);
        end
        2: begin
          chk("c2_adr", imem_adr, 32'h8);
          chk("c2_valid", {31'd0, inst_valid}, 32'd1);
        end
        3: chk("c3_adr", imem_adr, 32'hC);
        4: chk("stall_full_req", {31'd0, imem_req}, 32'd0);
        5, 6, 7, 8: begin
          chk("stall_req", {31'd0, imem_req}, 32'd0);
          chk("stall_valid", {31'd0, inst_valid}, 32'd1);
          chk("stall_inst", inst, 32'h8);
          chk("stall_pc4", inst_pc4, 32'hC);
        end
        16: chk("br_req_blocked", {31'd0, imem_req}, 32'd0);
        17: begin
          chk("br_flush_valid", {31'd0, inst_valid}, 32'd0);
          chk("br_req", {31'd0, imem_req}, 32'd1);
          chk("br_adr", imem_adr, 32'h38);
        end
        18: chk("br_t2_valid", {31'd0, inst_valid}, 32'd0);
        19: begin
          chk("br_t3_valid", {31'd0, inst_valid}, 32'd1);
          chk("br_t3_inst", inst, 32'h38);
        end
        23: chk("wrap_adr0", imem_adr, 32'hFFFF_FFF8);
        25: chk("wrap_adr2", imem_adr, 32'h0);
        26: begin
          chk("wrap_inst", inst, 32'hFFFF_FFFC);
          chk("wrap_pc4", inst_pc4, 32'h0);
        end
        29: begin
          chk("restart_req", {31'd0, imem_req}, 32'd1);
          chk("restart_adr", imem_adr, 32'h0);
          chk("restart_valid", {31'd0, inst_valid}, 32'd0);
        end
        30: chk("stale_ignored", {31'd0, inst_valid}, 32'd0);
        31: begin
          chk("restart_inst_valid", {31'd0, inst_valid}, 32'd1);
          chk("restart_inst", inst, 32'h0);
        end
        39: chk("kill_br_req", {31'd0, imem_req}, 32'd0);
        40: begin
          chk("kill_drop_req", {31'd0, imem_req}, 32'd0);
          chk("kill_drop_valid", {31'd0, inst_valid}, 32'd0);
        end
        41: begin
          chk("kill_tgt_req", {31'd0, imem_req}, 32'd1);
          chk("kill_tgt_adr", imem_adr, 32'h140);
          chk("kill_tgt_valid", {31'd0, inst_valid}, 32'd0);
        end
        47: chk("coinc_br_req", {31'd0, imem_req}, 32'd0);
        48: begin
          chk("coinc_req", {31'd0, imem_req}, 32'd1);
          chk("coinc_adr", imem_adr, 32'h200);
          chk("coinc_valid", {31'd0, inst_valid}, 32'd0);
        end
        52: begin
          chk("coinc_inst_valid", {31'd0, inst_valid}, 32'd1);
          chk("coinc_inst", inst, 32'h200);
        end
        default: ;
      endcase

      @(posedge clk);
      #1;
    end

    chk("sb_drained", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
